// File: rtl/bin2bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
// Holds the FSM state type, the BCD digit type and the over-range limit helper.
package bin2bcd_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  typedef logic [3:0] bcd_digit_t;

  localparam int unsigned LIMIT_W = 64;

  // Largest value representable in `digits` BCD digits (10^digits - 1), saturating at all-ones.
  function automatic logic [LIMIT_W-1:0] bcd_max_value(input int unsigned digits);
    logic [LIMIT_W-1:0] v;
    v = LIMIT_W'(1);
    for (int unsigned i = 0; i < digits; i++) begin
      if (v > LIMIT_W'(64'd1844674407370955161)) return '1;
      v = v * LIMIT_W'(10);
    end
    return v - LIMIT_W'(1);
  endfunction

endpackage

// File: rtl/bin2bcd_seq_bcd_add3.sv
// Per-digit double-dabble correction: a digit of 5 or more gets +3 before the shift.
// Ports: d_i  working BCD digit
//        d_c  corrected digit (combinational)
module bcd_add3
  import bin2bcd_pkg::*;
(
  input  bcd_digit_t d_i,
  output bcd_digit_t d_c
);

  always_comb begin
    d_c = (d_i >= 4'd5) ? (d_i + 4'd3) : d_i;
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// Ports: clk, rst_n (async, active-low)
//        start_i/bin_i  request and value, accepted only while idle
//        busy_o         conversion in progress
//        valid_o        one-cycle pulse when bcd_o/ovf_o are updated
//        bcd_o          packed BCD result, digit 0 in [3:0]
//        ovf_o          input exceeded 10^DIGITS-1 (only with saturation)
// Build option: define BIN2BCD_SAT_EN to saturate over-range inputs to all nines
// and report ovf_o; otherwise the result wraps modulo 10^DIGITS and ovf_o is 0.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int unsigned BIN_W  = 16,
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [BIN_W-1:0]      bin_i,
  output logic                  busy_o,
  output logic                  valid_o,
  output logic [4*DIGITS-1:0]   bcd_o,
  output logic                  ovf_o
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);

  state_e             state_q, state_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [BCD_W-1:0]   work_q, work_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               valid_q, valid_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [BCD_W-1:0]   work_adj_c;
  logic [BCD_W-1:0]   shift_c;

  // Add-3 correction on every working digit ahead of the shift.
  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .d_i (work_q[4*g +: 4]),
      .d_c (work_adj_c[4*g +: 4])
    );
  end

  // Shift {BCD, bin} left by one; the carry out of the top digit falls off.
  assign shift_c = BCD_W'({work_adj_c, bin_q[BIN_W-1]});

`ifdef BIN2BCD_SAT_EN
  localparam int unsigned CMP_W = (BIN_W > LIMIT_W) ? BIN_W : LIMIT_W;
  localparam logic [LIMIT_W-1:0] MAX_VAL   = bcd_max_value(DIGITS);
  localparam logic [BCD_W-1:0]   ALL_NINES = {DIGITS{4'h9}};

  logic ovf_flag_q, ovf_flag_d;
  logic ovf_q, ovf_d;
  logic over_c;

  assign over_c = CMP_W'(bin_i) > CMP_W'(MAX_VAL);
`endif

  // Next-state and datapath.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    valid_d = 1'b0;
    bcd_d   = bcd_q;
`ifdef BIN2BCD_SAT_EN
    ovf_flag_d = ovf_flag_q;
    ovf_d      = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_i) begin
          bin_d   = bin_i;
          work_d  = '0;
          cnt_d   = CNT_W'(BIN_W - 1);
          busy_d  = 1'b1;
          state_d = SHIFT;
`ifdef BIN2BCD_SAT_EN
          ovf_flag_d = over_c;
`endif
        end
      end
      SHIFT: begin
        bin_d  = bin_q << 1;
        work_d = shift_c;
        if (cnt_q == '0) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          valid_d = 1'b1;
`ifdef BIN2BCD_SAT_EN
          bcd_d = ovf_flag_q ? ALL_NINES : shift_c;
          ovf_d = ovf_flag_q;
`else
          bcd_d = shift_c;
`endif
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bin_q   <= '0;
      work_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      bcd_q   <= '0;
`ifdef BIN2BCD_SAT_EN
      ovf_flag_q <= 1'b0;
      ovf_q      <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      bcd_q   <= bcd_d;
`ifdef BIN2BCD_SAT_EN
      ovf_flag_q <= ovf_flag_d;
      ovf_q      <= ovf_d;
`endif
    end
  end

  assign busy_o  = busy_q;
  assign valid_o = valid_q;
  assign bcd_o   = bcd_q;
`ifdef BIN2BCD_SAT_EN
  assign ovf_o   = ovf_q;
`else
  assign ovf_o   = 1'b0;
`endif

endmodule
